// File: rtl/clk_freq_meter_pkg.sv
// rtl/clk_freq_meter_pkg.sv - shared clock utilities for the frequency meter
//
// Contents:
//   ST_IDLE / ST_MEASURE / ST_DONE : FSM state encodings
//   expected_count()               : edge count a parent should expect for a
//                                    given input frequency, used to pick
//                                    EXP_MIN / EXP_MAX
//   in_window()                    : inclusive range compare

package clk_freq_meter_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_MEASURE = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   // GATE_CYCLES * f_meas / CLK_REF_FREQ, evaluated at elaboration by parents.
   function automatic longint unsigned expected_count(
      input longint unsigned gate_cycles,
      input longint unsigned f_meas_hz,
      input longint unsigned f_ref_hz
   );
      return (gate_cycles * f_meas_hz) / f_ref_hz;
   endfunction

   // Inclusive window test; kept as a function so a zero lower bound does not
   // turn into a constant comparison inside the parent.
   function automatic logic in_window(
      input logic [31:0] value,
      input logic [31:0] lo,
      input logic [31:0] hi
   );
      return (value >= lo) && (value <= hi);
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchronizer with rising-edge pulse
//
// Ports:
//   clk_i   : sampling clock
//   rst_ni  : asynchronous active-low reset, all flops clear to 0
//   async_i : input asynchronous to clk_i (clock under test, button, ...)
//   edge_o  : one-cycle pulse per synchronized rising edge of async_i

module sync_edge_detect (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic edge_o
);

   logic sync1_q;
   logic sync2_q;
   logic hist_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b0;
      end else begin
         sync1_q <= async_i;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end
   end

   assign edge_o = sync2_q & ~hist_q;

endmodule

// File: rtl/clk_freq_meter.sv
// rtl/clk_freq_meter.sv - counts rising edges of a slow clock over a fixed gate window
//
// Ports:
//   clk_i      : reference clock
//   rst_ni     : asynchronous active-low reset
//   meas_clk_i : signal under measurement, asynchronous to clk_i
//   start_i    : level, sampled only while idle
//   busy_o     : high while measuring and in the result cycle
//   valid_o    : one-cycle pulse, new result on count_o / in_range_o
//   count_o    : last completed edge count, held until the next result
//   in_range_o : EXP_MIN <= count_o <= EXP_MAX, updated with count_o

module clk_freq_meter
   import clk_freq_meter_pkg::*;
#(
   parameter int unsigned CLK_REF_FREQ = 50_000_000,
   parameter int unsigned GATE_CYCLES  = 50_000,
   parameter int unsigned EXP_MIN      = 0,
   parameter int unsigned EXP_MAX      = 32'hFFFF_FFFF,
   parameter bit          CONTINUOUS   = 1'b0,
   localparam int         COUNT_W      = $clog2(GATE_CYCLES + 1)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               meas_clk_i,
   input  logic               start_i,
   output logic               busy_o,
   output logic               valid_o,
   output logic [COUNT_W-1:0] count_o,
   output logic               in_range_o
);

   if (GATE_CYCLES < 2 || CLK_REF_FREQ == 0) begin : g_bad_param
      $error("clk_freq_meter: GATE_CYCLES must be >= 2 and CLK_REF_FREQ non-zero");
   end

   localparam logic [COUNT_W-1:0] GATE_LAST = COUNT_W'(GATE_CYCLES - 1);

   logic               edge_p;
   logic [1:0]         state_q,    state_d;
   logic [COUNT_W-1:0] gate_cnt_q, gate_cnt_d;
   logic [COUNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [COUNT_W-1:0] count_q,    count_d;
   logic               in_range_q, in_range_d;
   logic [COUNT_W-1:0] edge_inc;

   sync_edge_detect u_sync (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .async_i (meas_clk_i),
      .edge_o  (edge_p)
   );

   // Saturating increment; also feeds the result registers so an edge in the
   // last gate cycle is part of the reported count.
   always_comb begin
      edge_inc = edge_cnt_q;
      if (edge_p && !(&edge_cnt_q)) begin
         edge_inc = edge_cnt_q + COUNT_W'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      gate_cnt_d = gate_cnt_q;
      edge_cnt_d = edge_cnt_q;
      count_d    = count_q;
      in_range_d = in_range_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d    = ST_MEASURE;
               gate_cnt_d = '0;
               edge_cnt_d = '0;
            end
         end
         ST_MEASURE: begin
            gate_cnt_d = gate_cnt_q + COUNT_W'(1);
            edge_cnt_d = edge_inc;
            if (gate_cnt_q == GATE_LAST) begin
               state_d    = ST_DONE;
               count_d    = edge_inc;
               in_range_d = in_window(32'(edge_inc), EXP_MIN, EXP_MAX);
            end
         end
         ST_DONE: begin
            // Counters are cleared here so a continuous re-arm starts clean.
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            state_d    = CONTINUOUS ? ST_MEASURE : ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         count_q    <= '0;
         in_range_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gate_cnt_q <= gate_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         count_q    <= count_d;
         in_range_q <= in_range_d;
      end
   end

   assign busy_o     = (state_q != ST_IDLE);
   assign valid_o    = (state_q == ST_DONE);
   assign count_o    = count_q;
   assign in_range_o = in_range_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// tb/tb_clk_freq_meter.sv - self-checking bench for clk_freq_meter

module tb_clk_freq_meter;

   localparam int G    = 1000;
   localparam int CW   = $clog2(G + 1);
   localparam int MAXC = 20000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic meas = 1'b0;
   logic start_a = 1'b0;
   logic start_b = 1'b0;
   logic busy_a, valid_a, inr_a;
   logic busy_b, valid_b, inr_b;
   logic [CW-1:0] cnt_a, cnt_b;

   clk_freq_meter #(
      .CLK_REF_FREQ (50_000_000),
      .GATE_CYCLES  (G),
      .EXP_MIN      (240),
      .EXP_MAX      (260),
      .CONTINUOUS   (1'b0)
   ) u_dut_a (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .meas_clk_i (meas),
      .start_i    (start_a),
      .busy_o     (busy_a),
      .valid_o    (valid_a),
      .count_o    (cnt_a),
      .in_range_o (inr_a)
   );

   clk_freq_meter #(
      .CLK_REF_FREQ (50_000_000),
      .GATE_CYCLES  (G),
      .EXP_MIN      (251),
      .EXP_MAX      (260),
      .CONTINUOUS   (1'b1)
   ) u_dut_b (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .meas_clk_i (meas),
      .start_i    (start_b),
      .busy_o     (busy_b),
      .valid_o    (valid_b),
      .count_o    (cnt_b),
      .in_range_o (inr_b)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Stimulus for meas: toggles at negedges every 'half' cycles, or holds
   // 'hold' when half is 0. Each rising edge is logged by the cycle count at
   // the negedge where it was driven.
   int   half = 5;
   logic hold = 1'b0;
   int   ph = 0;
   bit   rose [0:MAXC-1];

   always @(negedge clk) begin : gen
      logic prev;
      prev = meas;
      if (half == 0) begin
         meas = hold;
      end else begin
         ph++;
         if (ph >= half) begin
            ph = 0;
            meas = ~meas;
         end
      end
      if (meas && !prev && cyc < MAXC) rose[cyc] = 1'b1;
   end

   // A rise driven at negedge m is captured at edge m+1, gives edge_p in the
   // following cycle and is counted at edge m+3. A window started at edge s
   // counts edges s+1 .. s+G.
   function automatic int model_count(input int s);
      int c = 0;
      for (int m = s - 2; m <= s + G - 3; m++) begin
         if (m >= 0 && m < MAXC && rose[m]) c++;
      end
      return c;
   endfunction

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   typedef struct {
      int s;
      int vcyc;
   } win_t;

   win_t q_a[$];
   win_t q_b[$];

   always @(negedge clk) begin : mon_a
      win_t w;
      int   c;
      if (valid_a) begin
         if (q_a.size() == 0) begin
            chk("a_unexpected_valid", 1, 0);
         end else begin
            w = q_a.pop_front();
            c = model_count(w.s);
            chk("a_valid_cycle", cyc, w.vcyc);
            chk("a_count", cnt_a, c);
            chk("a_in_range", inr_a, (c >= 240 && c <= 260));
         end
      end
   end

   always @(negedge clk) begin : mon_b
      win_t w;
      int   c;
      if (valid_b) begin
         if (q_b.size() == 0) begin
            chk("b_unexpected_valid", 1, 0);
         end else begin
            w = q_b.pop_front();
            c = model_count(w.s);
            chk("b_valid_cycle", cyc, w.vcyc);
            chk("b_count", cnt_b, c);
            chk("b_in_range", inr_b, (c >= 251 && c <= 260));
         end
      end
   end

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Called at a negedge; start is sampled at the next posedge (edge s).
   task automatic start_a_once(output int s);
      start_a = 1'b1;
      s = cyc + 1;
      q_a.push_back('{s: s, vcyc: s + G});
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic start_b_once(output int s);
      start_b = 1'b1;
      s = cyc + 1;
      @(negedge clk);
      start_b = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      q_a.delete();
      q_b.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int s;
      repeat (3) @(negedge clk);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_valid_a", valid_a, 0);
      chk("rst_count_a", cnt_a, 0);
      chk("rst_in_range_a", inr_a, 0);
      chk("rst_busy_b", busy_b, 0);
      chk("rst_count_b", cnt_b, 0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // Period 10, single start, busy framing
      chk("t1_busy_before", busy_a, 0);
      start_a_once(s);
      chk("t1_busy_first", busy_a, 1);
      wait_cyc(s + G);
      chk("t1_busy_done", busy_a, 1);
      chk("t1_valid_done", valid_a, 1);
      wait_cyc(s + G + 1);
      chk("t1_busy_after", busy_a, 0);
      chk("t1_valid_after", valid_a, 0);

      // Stuck low, then stuck high
      half = 0; hold = 1'b0;
      repeat (10) @(negedge clk);
      start_a_once(s);
      wait_cyc(s + G + 2);
      hold = 1'b1;
      repeat (10) @(negedge clk);
      start_a_once(s);
      wait_cyc(s + G + 2);

      // Period 4: in range on instance a
      hold = 1'b0; ph = 0; half = 2;
      repeat (10) @(negedge clk);
      start_a_once(s);
      wait_cyc(s + G + 2);

      // Max rate with start pulses mid-window
      half = 1;
      repeat (10) @(negedge clk);
      start_a_once(s);
      wait_cyc(s + 300);
      start_a = 1'b1;
      repeat (5) @(negedge clk);
      start_a = 1'b0;
      wait_cyc(s + G + 2);

      // Reset in the middle of a window
      half = 5;
      start_a_once(s);
      wait_cyc(s + 400);
      rst_n = 1'b0;
      q_a.delete();
      #1;
      chk("rst_mid_busy", busy_a, 0);
      chk("rst_mid_valid", valid_a, 0);
      chk("rst_mid_count", cnt_a, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wait_cyc(s + G + 10);
      @(negedge clk);
      start_a_once(s);
      wait_cyc(s + G + 2);

      // start held high, CONTINUOUS = 0: spacing G+2
      start_a = 1'b1;
      s = cyc + 1;
      for (int k = 0; k < 3; k++) q_a.push_back('{s: s + k * (G + 2), vcyc: s + k * (G + 2) + G});
      wait_cyc(s + 2 * (G + 2) + 10);
      start_a = 1'b0;
      wait_cyc(s + 2 * (G + 2) + G + 3);

      // Period 4 on instance b (EXP_MIN 251), stopped by reset after one result
      ph = 0; half = 2;
      repeat (10) @(negedge clk);
      start_b_once(s);
      q_b.push_back('{s: s, vcyc: s + G});
      wait_cyc(s + G + 3);
      pulse_reset();

      // CONTINUOUS = 1: spacing G+1, period 10
      half = 5;
      repeat (10) @(negedge clk);
      start_b_once(s);
      for (int k = 0; k < 3; k++) q_b.push_back('{s: s + k * (G + 1), vcyc: s + k * (G + 1) + G});
      wait_cyc(s + 2 * (G + 1) + G + 3);
      chk("b_cont_busy", busy_b, 1);
      chk("a_queue_empty", q_a.size(), 0);
      chk("b_queue_empty", q_b.size(), 0);
      pulse_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clk_freq_meter.md
# clk_freq_meter

Measures the frequency of a slow clock or toggle signal by counting its rising edges over a fixed gate window of reference-clock cycles. It is the checking end of the on-chip clock dividers: it consumes a derived clock such as the 25 MHz pixel clock, or a slower divided tick, as an ordinary asynchronous input. It reports the edge count with a range flag, for bring-up, self-test and lock indication.

## Interface
- `CLK_REF_FREQ`, default 50_000_000: reference clock frequency in Hz. Documentation only; it does not enter the arithmetic.
- `GATE_CYCLES`, default 50_000: gate window length in `clk_i` cycles (1 ms at 50 MHz). Must be ≥ 2.
- `EXP_MIN`, default 0: lowest edge count accepted as in range.
- `EXP_MAX`, default all-ones: highest edge count accepted as in range.
- `CONTINUOUS`, default 0: 1 = re-arm automatically after every result.
- `COUNT_W` (localparam) = `$clog2(GATE_CYCLES+1)`.

Ports:
- `clk_i`, input, 1: reference clock. Single clock domain.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `meas_clk_i`, input, 1: signal under measurement, asynchronous to `clk_i`.
- `start_i`, input, 1: level; sampled only in IDLE.
- `busy_o`, output, 1: high in MEASURE and DONE.
- `valid_o`, output, 1: one-cycle pulse, new result present.
- `count_o`, output, COUNT_W: last completed edge count; held until the next result.
- `in_range_o`, output, 1: `EXP_MIN ≤ count_o ≤ EXP_MAX`; updated together with `count_o`.

## Operation
- Synchronizer: `meas_clk_i` passes through two flops, then a third flop for edge history. All three reset to 0.
- `edge_p` = sync2 & ~sync3. It runs in every state.
- FSM states: IDLE, MEASURE, DONE. Reset state is IDLE.
- IDLE:
  - `start_i` = 1 → MEASURE, with `gate_cnt` ← 0 and `edge_cnt` ← 0.
  - `edge_p` is ignored in IDLE.
- MEASURE:
  - `gate_cnt` increments every cycle.
  - `edge_cnt` increments on each `edge_p` and saturates at 2^COUNT_W−1.
  - When `gate_cnt` = GATE_CYCLES−1, the FSM goes to DONE. An `edge_p` in that final cycle is counted.
- DONE (exactly one cycle):
  - `count_o` ← `edge_cnt`, `in_range_o` ← the range compare, and `valid_o` = 1, all registered and visible in this cycle.
  - Next state is MEASURE if `CONTINUOUS` = 1 (counters cleared), otherwise IDLE.
- `start_i` is ignored in MEASURE and DONE; there is no restart mid-window.
- An edge pulse already in the synchronizer pipeline when MEASURE is entered counts if its `edge_p` falls inside MEASURE.
- Saturation cannot occur with legal input, because `edge_p` fires at most every 2nd cycle. It is still required.

## Timing
- Reset values: `busy_o` = 0, `valid_o` = 0, `count_o` = 0, `in_range_o` = 0; all internal counters 0.
- Take cycle 0 as the edge where `start_i` is sampled high in IDLE:
  - MEASURE occupies cycles 1 … GATE_CYCLES.
  - DONE, with `valid_o` = 1, is cycle GATE_CYCLES+1.
- Input latency: a rising edge of `meas_clk_i` produces `edge_p` 2–3 `clk_i` edges later.
- Back-to-back results:
  - With `start_i` held high and CONTINUOUS = 0, there is one IDLE cycle between results, so `valid_o` recurs every GATE_CYCLES+2 cycles.
  - With CONTINUOUS = 1, `valid_o` recurs every GATE_CYCLES+1 cycles; there is 1 dead cycle per window.
- Reset asserted mid-operation: immediate return to IDLE, no `valid_o`, and `count_o` cleared to 0.
- Maximum measurable rate is `clk_i`/2 (`meas_clk_i` toggling every `clk_i` cycle). Faster inputs alias and the result is undefined.

## Structure
- Shared package (clock utilities):
  - FSM state encodings ST_IDLE / ST_MEASURE / ST_DONE.
  - Helper function computing expected count = GATE_CYCLES·f_meas/CLK_REF_FREQ, used by parents to set EXP_MIN/EXP_MAX.
- One sub-module: `sync_edge_detect`. It holds the 2-FF synchronizer, the history flop, the rising-edge pulse and the async active-low reset, and it is reusable for buttons and other async inputs.
- Top contains the FSM, the gate counter, the saturating edge counter and the result registers.

## Test plan
- GATE_CYCLES = 1000, `meas_clk_i` toggling every 5 `clk_i` cycles (period 10), single start at cycle 0 → `valid_o` only at cycle 1001, `count_o` = 100 ±1, `busy_o` high in cycles 1–1001.
- Period 4 input, EXP_MIN = 240, EXP_MAX = 260 → `count_o` = 250 ±1, `in_range_o` = 1. Repeat with EXP_MIN = 251 → `in_range_o` = 0 (unless the count is 251).
- `meas_clk_i` stuck low, then stuck high → `count_o` = 0, `in_range_o` = 0 with default EXP_MIN = 1 override, `valid_o` still fires at cycle 1001.
- Max rate: input toggles every `clk_i` cycle → `count_o` = 500 ±1. `start_i` pulses during MEASURE have no effect.
- `rst_ni` driven low at cycle 400 of a window → `busy_o`, `valid_o`, `count_o` all 0 immediately. No `valid_o` follows, and the next start measures normally.
- `start_i` held high: CONTINUOUS = 0 gives `valid_o` spacing 1002; CONTINUOUS = 1 gives spacing 1001. Every result equals the period-10 value 100 ±1.
